// File: rtl/ysyx_23060059_lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - lsu_state_e   : controller states (IDLE, REQ, WAIT, DONE)
//   - WMASK_B/H/W   : store size encodings (wmask[3:0])
//   - RMASK_B/H/W   : load size encodings (rmask)
//   - is_misaligned : true when the access size does not match the address alignment
package ysyx_23060059_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [3:0]  WMASK_B = 4'h1;
  localparam logic [3:0]  WMASK_H = 4'h3;
  localparam logic [3:0]  WMASK_W = 4'hF;
  localparam logic [31:0] RMASK_B = 32'h0000_00FF;
  localparam logic [31:0] RMASK_H = 32'h0000_FFFF;
  localparam logic [31:0] RMASK_W = 32'hFFFF_FFFF;

  // Builds the set of address bits that must be zero for the access size;
  // unrecognised encodings are treated as word accesses.
  function automatic logic is_misaligned(input logic        is_store,
                                         input logic [3:0]  wmask,
                                         input logic [31:0] rmask,
                                         input logic [1:0]  off);
    logic [1:0] need_zero;
    if (is_store)
      need_zero = (wmask == WMASK_W) ? 2'b11 :
                  (wmask == WMASK_H) ? 2'b01 :
                  (wmask == WMASK_B) ? 2'b00 : 2'b11;
    else
      need_zero = (rmask == RMASK_W) ? 2'b11 :
                  (rmask == RMASK_H) ? 2'b01 :
                  (rmask == RMASK_B) ? 2'b00 : 2'b11;
    return (off & need_zero) != 2'b00;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: shifts the bus word down by the byte offset,
// masks it to the access size and optionally sign-extends byte/half loads.
// Ports:
//   rdata_i    : raw 32-bit word from the data bus
//   off_i      : byte offset addr[1:0]
//   rmask_i    : load size mask (RMASK_B/H/W)
//   m_signed_i : sign-extend the result
//   data_o     : aligned, extended load value
module lsu_load_align
  import ysyx_23060059_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rmask_i,
  input  logic        m_signed_i,
  output logic [31:0] data_o
);

  logic [31:0] masked;

  always_comb begin
    masked = (rdata_i >> {off_i, 3'b000}) & rmask_i;
    data_o = masked;
    if (m_signed_i) begin
      if (rmask_i == RMASK_B)
        data_o = {{24{masked[7]}}, masked[7:0]};
      else if (rmask_i == RMASK_H)
        data_o = {{16{masked[15]}}, masked[15:0]};
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store stage between exu and wbu. Captures one bundle per handshake,
// issues at most one request on the data bus, and presents the write-back
// bundle (data, rd, reg_en, pc, error) to wbu.
// Ports:
//   clk, rst (asynchronous, active-low)
//   exu side : lsu_receive_valid, lsu_send_ready, addr_i, wdata_i, ren_i, wen_i,
//              wmask_i, rmask_i, m_signed_i, rd_i, reg_en_i, pc_i
//   bus      : mem_req_valid/ready, mem_req_we, mem_addr, mem_wdata, mem_wstrb,
//              mem_resp_valid, mem_rdata, mem_resp_err
//   wbu side : lsu_send_valid, lsu_receive_ready, wb_data_o, rd_o, reg_en_o,
//              pc_o, lsu_err_o
// Optional feature: define YSYX_23060059_LSU_TIMEOUT_EN to add a WAIT-state
// watchdog that gives up after TIMEOUT_CYCLES cycles with an access fault.
module lsu
  import ysyx_23060059_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_receive_valid,
  output logic        lsu_send_ready,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        ren_i,
  input  logic        wen_i,
  input  logic [7:0]  wmask_i,
  input  logic [31:0] rmask_i,
  input  logic        m_signed_i,
  input  logic [4:0]  rd_i,
  input  logic        reg_en_i,
  input  logic [31:0] pc_i,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp_err,
  output logic        lsu_send_valid,
  input  logic        lsu_receive_ready,
  output logic [31:0] wb_data_o,
  output logic [4:0]  rd_o,
  output logic        reg_en_o,
  output logic [31:0] pc_o,
  output logic        lsu_err_o
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rmask_q, rmask_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        signed_q, signed_d, store_q, store_d, reg_en_in_q, reg_en_in_d;
  logic [31:0] wb_data_q, wb_data_d, pc_q, pc_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_en_q, reg_en_d, err_q, err_d;
  logic [31:0] load_data;
  logic        is_mem, misal, timeout;
  logic        unused_wmask_hi;

  // Only bits [3:0] of wmask carry the store size.
  assign unused_wmask_hi = ^wmask_i[7:4];

  lsu_load_align u_load_align (
    .rdata_i    (mem_rdata),
    .off_i      (addr_q[1:0]),
    .rmask_i    (rmask_q),
    .m_signed_i (signed_q),
    .data_o     (load_data)
  );

`ifdef YSYX_23060059_LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Held at zero outside WAIT, so it restarts from zero on every WAIT entry.
  assign tmo_cnt_d = (state_q == S_WAIT) ? tmo_cnt_q + 1'b1 : '0;
  // The count reaches TIMEOUT_CYCLES at the end of the cycle where it shows TIMEOUT_CYCLES-1.
  assign timeout   = (state_q == S_WAIT) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_cnt_q <= '0;
    else      tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rmask_d     = rmask_q;
    wmask_d     = wmask_q;
    signed_d    = signed_q;
    store_d     = store_q;
    reg_en_in_d = reg_en_in_q;
    wb_data_d   = wb_data_q;
    pc_d        = pc_q;
    rd_d        = rd_q;
    reg_en_d    = reg_en_q;
    err_d       = err_q;
    is_mem      = ren_i | wen_i;
    misal       = is_misaligned(wen_i, wmask_i[3:0], rmask_i, addr_i[1:0]);

    unique case (state_q)
      S_IDLE: begin
        if (lsu_receive_valid) begin
          addr_d      = addr_i;
          wdata_d     = wdata_i;
          rmask_d     = rmask_i;
          wmask_d     = wmask_i[3:0];
          signed_d    = m_signed_i;
          store_d     = wen_i;        // ren&wen together is handled as a store
          reg_en_in_d = reg_en_i;
          rd_d        = rd_i;
          pc_d        = pc_i;
          if (!is_mem) begin
            wb_data_d = addr_i;
            err_d     = 1'b0;
            reg_en_d  = reg_en_i;
            state_d   = S_DONE;
          end else if (misal) begin
            wb_data_d = 32'h0;
            err_d     = 1'b1;
            reg_en_d  = 1'b0;
            state_d   = S_DONE;
          end else begin
            state_d   = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          wb_data_d = store_q ? 32'h0 : load_data;
          err_d     = mem_resp_err;
          reg_en_d  = reg_en_in_q & ~store_q & ~mem_resp_err;
          state_d   = S_DONE;
        end else if (timeout) begin
          wb_data_d = 32'h0;
          err_d     = 1'b1;
          reg_en_d  = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (lsu_receive_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rmask_q     <= '0;
      wmask_q     <= '0;
      signed_q    <= 1'b0;
      store_q     <= 1'b0;
      reg_en_in_q <= 1'b0;
      wb_data_q   <= '0;
      pc_q        <= '0;
      rd_q        <= '0;
      reg_en_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rmask_q     <= rmask_d;
      wmask_q     <= wmask_d;
      signed_q    <= signed_d;
      store_q     <= store_d;
      reg_en_in_q <= reg_en_in_d;
      wb_data_q   <= wb_data_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      reg_en_q    <= reg_en_d;
      err_q       <= err_d;
    end
  end

  assign lsu_send_ready = (state_q == S_IDLE);
  assign mem_req_valid  = (state_q == S_REQ);
  assign mem_req_we     = store_q;
  assign mem_addr       = {addr_q[31:2], 2'b00};
  assign mem_wstrb      = wmask_q << addr_q[1:0];
  assign mem_wdata      = wdata_q << {addr_q[1:0], 3'b000};
  assign lsu_send_valid = (state_q == S_DONE);
  assign wb_data_o      = wb_data_q;
  assign rd_o           = rd_q;
  assign reg_en_o       = reg_en_q;
  assign pc_o           = pc_q;
  assign lsu_err_o      = err_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  localparam int TMO = 4;

  logic        clk, rst_n;
  logic        lsu_receive_valid, lsu_send_ready;
  logic [31:0] addr_i, wdata_i, rmask_i, pc_i;
  logic        ren_i, wen_i, m_signed_i, reg_en_i;
  logic [7:0]  wmask_i;
  logic [4:0]  rd_i;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid, mem_resp_err;
  logic        lsu_send_valid, lsu_receive_ready;
  logic [31:0] wb_data_o, pc_o;
  logic [4:0]  rd_o;
  logic        reg_en_o, lsu_err_o;

  lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst_n),
    .lsu_receive_valid(lsu_receive_valid), .lsu_send_ready(lsu_send_ready),
    .addr_i(addr_i), .wdata_i(wdata_i), .ren_i(ren_i), .wen_i(wen_i),
    .wmask_i(wmask_i), .rmask_i(rmask_i), .m_signed_i(m_signed_i),
    .rd_i(rd_i), .reg_en_i(reg_en_i), .pc_i(pc_i),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
    .lsu_send_valid(lsu_send_valid), .lsu_receive_ready(lsu_receive_ready),
    .wb_data_o(wb_data_o), .rd_o(rd_o), .reg_en_o(reg_en_o), .pc_o(pc_o),
    .lsu_err_o(lsu_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] wb;
    logic        err;
    logic        reg_en;
    logic [4:0]  rd;
    logic [31:0] pc;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  logic chk_en = 1'b0;
  logic exp_ready, exp_req, exp_send;
  exp_t ex;
  logic [31:0] last_wb, last_maddr, last_mwdata;
  logic [3:0]  last_wstrb;
  logic        last_err, last_reg_en;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Reference behaviour derived from access size and byte offset arithmetic.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] wd,
                                 input logic r, input logic w,
                                 input logic [7:0] wm, input logic [31:0] rm,
                                 input logic sg, input logic ren_v,
                                 input logic [31:0] rdat, input logic rerr);
    exp_t e;
    int nbytes, off;
    logic [31:0] szmask, v;
    e = '0;
    off = int'(a % 4);
    if (!r && !w) begin
      e.wb = a;
      e.reg_en = ren_v;
      return e;
    end
    if (w) nbytes = (wm[3:0] == 4'h1) ? 1 : (wm[3:0] == 4'h3) ? 2 : 4;
    else   nbytes = (rm == 32'hFF) ? 1 : (rm == 32'hFFFF) ? 2 : 4;
    if ((off % nbytes) != 0) begin
      e.err = 1'b1;
      return e;
    end
    e.mem   = 1'b1;
    e.we    = w;
    e.addr  = a - 32'(off);
    e.wstrb = 4'(((1 << nbytes) - 1) << off);
    e.wdata = wd << (8 * off);
    if (w) begin
      e.err = rerr;
    end else begin
      szmask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      v = (rdat >> (8 * off)) & szmask;
      if (sg && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~szmask;
      e.wb = v;
      e.err = rerr;
      e.reg_en = ren_v && !rerr;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("send_ready", {31'b0, lsu_send_ready}, {31'b0, exp_ready});
      chk("req_valid", {31'b0, mem_req_valid}, {31'b0, exp_req});
      chk("send_valid", {31'b0, lsu_send_valid}, {31'b0, exp_send});
      if (exp_req) begin
        chk("mem_addr", mem_addr, ex.addr);
        chk("mem_we", {31'b0, mem_req_we}, {31'b0, ex.we});
        if (ex.we) begin
          chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, ex.wstrb});
          chk("mem_wdata", mem_wdata, ex.wdata);
        end
        last_maddr = mem_addr; last_wstrb = mem_wstrb; last_mwdata = mem_wdata;
      end
      if (exp_send) begin
        chk("wb_data", wb_data_o, ex.wb);
        chk("err", {31'b0, lsu_err_o}, {31'b0, ex.err});
        chk("reg_en", {31'b0, reg_en_o}, {31'b0, ex.reg_en});
        chk("rd", {27'b0, rd_o}, {27'b0, ex.rd});
        chk("pc", pc_o, ex.pc);
        last_wb = wb_data_o; last_err = lsu_err_o; last_reg_en = reg_en_o;
      end
    end
  end

  task automatic scramble();
    addr_i = $urandom; wdata_i = $urandom; ren_i = 1'($urandom); wen_i = 1'($urandom);
    wmask_i = 8'($urandom); rmask_i = $urandom; m_signed_i = 1'($urandom);
    rd_i = 5'($urandom); reg_en_i = 1'($urandom); pc_i = $urandom;
  endtask

  // resp_dl == 0 means the bus never answers (watchdog case).
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic r, input logic w,
                     input logic [7:0] wm, input logic [31:0] rm, input logic sg,
                     input logic [4:0] rdv, input logic ren_v, input logic [31:0] pcv,
                     input logic [31:0] rdat, input logic rerr,
                     input int req_st, input int resp_dl, input int out_st);
    exp_t e;
    e = model(a, wd, r, w, wm, rm, sg, ren_v, rdat, rerr);
    e.rd = rdv; e.pc = pcv;
    if (e.mem && resp_dl == 0) begin e.wb = '0; e.err = 1'b1; e.reg_en = 1'b0; end
    addr_i = a; wdata_i = wd; ren_i = r; wen_i = w; wmask_i = wm; rmask_i = rm;
    m_signed_i = sg; rd_i = rdv; reg_en_i = ren_v; pc_i = pcv;
    lsu_receive_valid = 1'b1;
    exp_ready = 1'b1; exp_req = 1'b0; exp_send = 1'b0;
    @(posedge clk); #1;
    lsu_receive_valid = 1'b0;
    scramble();
    ex = e;
    exp_ready = 1'b0;
    if (e.mem) begin
      exp_req = 1'b1;
      for (int i = 0; i <= req_st; i++) begin
        mem_req_ready = (i == req_st);
        @(posedge clk); #1;
      end
      mem_req_ready = 1'b0;
      exp_req = 1'b0;
      if (resp_dl == 0) begin
        for (int j = 0; j < TMO; j++) begin @(posedge clk); #1; end
      end else begin
        for (int j = 1; j <= resp_dl; j++) begin
          mem_resp_valid = (j == resp_dl);
          mem_rdata      = (j == resp_dl) ? rdat : $urandom;
          mem_resp_err   = (j == resp_dl) ? rerr : 1'($urandom);
          @(posedge clk); #1;
        end
      end
      mem_resp_valid = 1'b0; mem_rdata = $urandom;
    end
    exp_send = 1'b1;
    for (int k = 0; k <= out_st; k++) begin
      lsu_receive_ready = (k == out_st);
      mem_resp_valid = (resp_dl == 0 && k == 0);   // late response must be ignored
      mem_rdata = $urandom; mem_resp_err = 1'($urandom);
      @(posedge clk); #1;
    end
    lsu_receive_ready = 1'b0; mem_resp_valid = 1'b0;
    exp_send = 1'b0; exp_ready = 1'b1;
    for (int g = 0; g < int'($urandom % 3); g++) begin
      mem_resp_valid = 1'($urandom);   // stale responses in IDLE
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b0;
  endtask

  task automatic rand_txn();
    int kind, sz;
    logic [31:0] a, rm;
    logic [7:0] wm;
    logic r, w;
    kind = int'($urandom % 4);
    sz = int'($urandom % 3);
    r = (kind == 1) || (kind == 3);
    w = (kind == 2) || (kind == 3);
    a = $urandom;
    if ($urandom % 4 != 0) a = a & ~((32'd1 << sz) - 32'd1);
    wm = {4'($urandom), (sz == 0) ? 4'h1 : (sz == 1) ? 4'h3 : 4'hF};
    rm = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
    txn(a, $urandom, r, w, wm, rm, 1'($urandom), 5'($urandom), 1'($urandom), $urandom,
        $urandom, ($urandom % 8 == 0), int'($urandom % 4), 1 + int'($urandom % 3),
        int'($urandom % 3));
  endtask

  initial begin
    rst_n = 1'b0;
    lsu_receive_valid = 1'b0; lsu_receive_ready = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0; mem_resp_err = 1'b0;
    scramble();
    exp_ready = 1'b1; exp_req = 1'b0; exp_send = 1'b0; ex = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_send_ready", {31'b0, lsu_send_ready}, 32'd1);
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_send_valid", {31'b0, lsu_send_valid}, 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    chk("rst_err", {31'b0, lsu_err_o}, 32'd0);
    chk("rst_reg_en", {31'b0, reg_en_o}, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // ALU pass-through
    txn(32'h1234, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 5'd3, 1'b1, 32'h8000_0000,
        32'h0, 1'b0, 0, 1, 0);
    chk("alu_wb_literal", last_wb, 32'h1234);
    // Signed byte load
    txn(32'h8000_0003, 32'h0, 1'b1, 1'b0, 8'h0, 32'hFF, 1'b1, 5'd7, 1'b1, 32'h8000_0004,
        32'h80AA_BBCC, 1'b0, 0, 1, 0);
    chk("lb_addr_literal", last_maddr, 32'h8000_0000);
    chk("lb_wb_literal", last_wb, 32'hFFFF_FF80);
    // Half store
    txn(32'h102, 32'hBEEF, 1'b0, 1'b1, 8'h3, 32'h0, 1'b0, 5'd9, 1'b1, 32'h8000_0008,
        32'h0, 1'b0, 0, 1, 0);
    chk("sh_wstrb_literal", {28'b0, last_wstrb}, 32'hC);
    chk("sh_wdata_literal", last_mwdata, 32'hBEEF_0000);
    chk("sh_reg_en_literal", {31'b0, last_reg_en}, 32'd0);
    // Misaligned word load
    txn(32'h101, 32'h0, 1'b1, 1'b0, 8'h0, 32'hFFFF_FFFF, 1'b0, 5'd1, 1'b1, 32'h8000_000C,
        32'h0, 1'b0, 0, 1, 0);
    chk("misal_err_literal", {31'b0, last_err}, 32'd1);
    // Backpressure on both sides
    txn(32'h2000_0010, 32'h0, 1'b1, 1'b0, 8'h0, 32'hFFFF, 1'b0, 5'd4, 1'b1, 32'h8000_0010,
        32'h1234_9876, 1'b0, 5, 2, 3);
    chk("bp_wb_literal", last_wb, 32'h0000_9876);

    for (int n = 0; n < 150; n++) rand_txn();

`ifdef YSYX_23060059_LSU_TIMEOUT_EN
    txn(32'h40, 32'h0, 1'b1, 1'b0, 8'h0, 32'hFFFF_FFFF, 1'b0, 5'd2, 1'b1, 32'h8000_0020,
        32'h0, 1'b0, 0, 0, 1);
    chk("tmo_err_literal", {31'b0, last_err}, 32'd1);
`endif

    // Reset asserted while a request is outstanding, then while waiting
    chk_en = 1'b0;
    addr_i = 32'h200; ren_i = 1'b1; wen_i = 1'b0; rmask_i = 32'hFFFF_FFFF;
    lsu_receive_valid = 1'b1;
    @(posedge clk); #1;
    lsu_receive_valid = 1'b0;
    chk("req_before_rst", {31'b0, mem_req_valid}, 32'd1);
    rst_n = 1'b0; #1;
    chk("req_after_rst", {31'b0, mem_req_valid}, 32'd0);
    chk("ready_after_rst_req", {31'b0, lsu_send_ready}, 32'd1);
    @(posedge clk); #1; rst_n = 1'b1;
    addr_i = 32'h204; ren_i = 1'b1; wen_i = 1'b0; rmask_i = 32'hFFFF_FFFF;
    lsu_receive_valid = 1'b1;
    @(posedge clk); #1;
    lsu_receive_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    chk("ready_in_wait", {31'b0, lsu_send_ready}, 32'd0);
    rst_n = 1'b0; #1;
    chk("req_after_rst_wait", {31'b0, mem_req_valid}, 32'd0);
    chk("ready_after_rst_wait", {31'b0, lsu_send_ready}, 32'd1);
    chk("send_after_rst_wait", {31'b0, lsu_send_valid}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    chk("stale_ready", {31'b0, lsu_send_ready}, 32'd1);
    chk("stale_send", {31'b0, lsu_send_valid}, 32'd0);

    // Normal operation resumes after reset
    exp_ready = 1'b1; exp_req = 1'b0; exp_send = 1'b0;
    chk_en = 1'b1;
    for (int n = 0; n < 20; n++) rand_txn();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
